// File: rtl/frame_buffer_pingpong.sv
// Ping-pong frame store: the capture side fills the back frame while the display reads the front frame.
// Front and back swap only at a display frame start, and only after a complete back frame has been written.
module frame_buffer_pingpong #(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned BANK_DEPTH   = 8192
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  wr_valid_i,
  input  logic                  wr_sof_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  output logic                  wr_frame_done_o,
  input  logic                  rd_frame_start_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  front_sel_o,
  output logic                  frame_ready_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int unsigned BANK_AW    = $clog2(BANK_DEPTH);
  localparam int unsigned NUM_BANKS  = (FRAME_PIXELS + BANK_DEPTH - 1) / BANK_DEPTH;
  localparam int unsigned PHYS_BANKS = 2 * NUM_BANKS;
  localparam int unsigned PHYS_W     = (PHYS_BANKS > 1) ? $clog2(PHYS_BANKS) : 1;
  localparam int unsigned SEL_W      = ADDR_WIDTH - BANK_AW;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DONE} wstate_t;

  wstate_t                 state, state_n;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_n;
  logic [ADDR_WIDTH-1:0]   wr_idx;
  logic                    wr_en, drop_inc, done_set, swap;

  logic [PHYS_W-1:0]       wr_phys, rd_phys, rd_phys1;
  logic [BANK_AW-1:0]      wr_local, rd_local;
  logic                    rd_zero, rd_v1, rd_zero1;
  logic [PHYS_BANKS-1:0][DATA_WIDTH-1:0] bank_dout;

  function automatic logic [PHYS_W-1:0] phys_bank(input logic frame, input logic [SEL_W-1:0] bank);
    return frame ? PHYS_W'(NUM_BANKS) + PHYS_W'(bank) : PHYS_W'(bank);
  endfunction

  // Write FSM state and bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state           <= W_IDLE;
      cnt             <= '0;
      wr_ready_o      <= 1'b1;
      wr_frame_done_o <= 1'b0;
      front_sel_o     <= 1'b0;
      frame_ready_o   <= 1'b0;
      drop_cnt_o      <= '0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      wr_ready_o      <= (state_n != W_DONE);
      wr_frame_done_o <= done_set;
      front_sel_o     <= front_sel_o ^ swap;
      frame_ready_o   <= frame_ready_o | swap;
      if (drop_inc && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // Next-state logic; a sof restarts the frame at index 0
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wr_en    = 1'b0;
    wr_idx   = cnt;
    drop_inc = 1'b0;
    done_set = 1'b0;
    swap     = 1'b0;
    case (state)
      W_IDLE: begin
        if (wr_valid_i && wr_sof_i) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          cnt_n   = ADDR_WIDTH'(1);
          state_n = W_FILL;
        end
      end
      W_FILL: begin
        if (wr_valid_i) begin
          wr_en = 1'b1;
          if (wr_sof_i) begin
            drop_inc = 1'b1;
            wr_idx   = '0;
            cnt_n    = ADDR_WIDTH'(1);
          end else if (cnt == LAST_IDX) begin
            state_n  = W_DONE;
            done_set = 1'b1;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + ADDR_WIDTH'(1);
          end
        end
      end
      W_DONE: begin
        if (rd_frame_start_i) begin
          swap    = 1'b1;
          state_n = W_IDLE;
        end
      end
      default: state_n = W_IDLE;
    endcase
  end

  assign wr_local = wr_idx[BANK_AW-1:0];
  assign wr_phys  = phys_bank(~front_sel_o, wr_idx[ADDR_WIDTH-1:BANK_AW]);
  assign rd_local = rd_addr_i[BANK_AW-1:0];
  assign rd_phys  = phys_bank(front_sel_o, rd_addr_i[ADDR_WIDTH-1:BANK_AW]);
  assign rd_zero  = ({1'b0, rd_addr_i} >= (ADDR_WIDTH + 1)'(FRAME_PIXELS)) || !frame_ready_o;

  // BRAM banks: one write port from the writer, one registered read port
  for (genvar b = 0; b < PHYS_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] dout;
    always_ff @(posedge clk_i) begin
      if (resetn_i && wr_en && (wr_phys == PHYS_W'(b))) mem[wr_local] <= wr_data_i;
      if (rd_en_i) dout <= mem[rd_local];
    end
    assign bank_dout[b] = dout;
  end

  // Read pipeline: bank select and front frame are captured with the request
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rd_v1      <= 1'b0;
      rd_zero1   <= 1'b0;
      rd_phys1   <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_v1      <= rd_en_i;
      rd_zero1   <= rd_zero;
      rd_phys1   <= rd_phys;
      rd_valid_o <= rd_v1;
      if (rd_v1) rd_data_o <= rd_zero1 ? '0 : bank_dout[rd_phys1];
    end
  end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Self-checking bench for frame_buffer_pingpong: directed scenarios plus random traffic
// compared every cycle against a frame-level reference model.
module tb_frame_buffer_pingpong;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned FP = 20;
  localparam int unsigned BD = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_valid, wr_sof, wr_ready, wr_frame_done;
  logic [DW-1:0] wr_data;
  logic          rd_frame_start, rd_en, rd_valid, front_sel, frame_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [15:0]   drop_cnt;

  frame_buffer_pingpong #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_PIXELS(FP), .BANK_DEPTH(BD)
  ) dut (
    .clk_i(clk), .resetn_i(resetn),
    .wr_valid_i(wr_valid), .wr_sof_i(wr_sof), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready), .wr_frame_done_o(wr_frame_done),
    .rd_frame_start_i(rd_frame_start), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .front_sel_o(front_sel), .frame_ready_o(frame_ready), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: two whole frames, a fill position, and a queue of pending reads
  logic [DW-1:0] mdl_mem [2][FP];
  logic          mdl_front, mdl_ready, mdl_complete, mdl_filling, exp_done;
  int            mdl_pos, mdl_drops;
  logic          p1_v, p2_v;
  logic [DW-1:0] p1_d, p2_d, exp_rd_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_front = 1'b0; mdl_ready = 1'b0; mdl_complete = 1'b0; mdl_filling = 1'b0;
    mdl_pos = 0; mdl_drops = 0; exp_done = 1'b0;
    p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0; exp_rd_data = '0;
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, check all outputs after it
  task automatic cycle(input logic v, input logic sof, input logic [DW-1:0] d,
                       input logic fs, input logic ren, input logic [AW-1:0] ra);
    logic [DW-1:0] nd;
    wr_valid = v; wr_sof = sof; wr_data = d;
    rd_frame_start = fs; rd_en = ren; rd_addr = ra;
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      nd = (!mdl_ready || int'(ra) >= int'(FP)) ? '0 : mdl_mem[mdl_front][ra];
      p2_v = p1_v; p2_d = p1_d;
      p1_v = ren;  p1_d = nd;
      if (p2_v) exp_rd_data = p2_d;
      exp_done = 1'b0;
      if (mdl_complete) begin
        if (fs) begin
          mdl_front = !mdl_front; mdl_ready = 1'b1;
          mdl_complete = 1'b0; mdl_filling = 1'b0;
        end
      end else if (v) begin
        if (sof) begin
          if (mdl_filling && mdl_drops < 65535) mdl_drops++;
          mdl_mem[!mdl_front][0] = d;
          mdl_pos = 1; mdl_filling = 1'b1;
        end else if (mdl_filling) begin
          mdl_mem[!mdl_front][mdl_pos] = d;
          mdl_pos++;
        end
        if (mdl_filling && mdl_pos == int'(FP)) begin
          mdl_complete = 1'b1; mdl_filling = 1'b0; exp_done = 1'b1;
        end
      end
    end
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(!mdl_complete));
    chk("wr_frame_done", 32'(wr_frame_done), 32'(exp_done));
    chk("front_sel", 32'(front_sel), 32'(mdl_front));
    chk("frame_ready", 32'(frame_ready), 32'(mdl_ready));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdl_drops));
    chk("rd_valid", 32'(rd_valid), 32'(p2_v));
    chk("rd_data", 32'(rd_data), 32'(exp_rd_data));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input int a);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(a));
  endtask

  // Pixels first..last of a frame with random gaps and random concurrent reads
  task automatic write_pixels(input int base, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      while ($urandom_range(0, 3) == 0)
        cycle(1'b0, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
      cycle(1'b1, (i == 0), DW'(base + i), 1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < int'(FP); a++) rd(a);
    rd(20); rd(31);
    idle(2);
  endtask

  initial begin
    model_reset();
    resetn = 1'b0;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    resetn = 1'b1;
    chk("reset_wr_ready", 32'(wr_ready), 32'd1);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    idle(2);

    // Reads before any swap return zero
    rd(0); rd(5); idle(2);
    chk("pre_swap_frame_ready", 32'(frame_ready), 32'd0);

    // First frame 0x100.., then swap
    write_pixels(32'h100, 0, int'(FP) - 1);
    idle(1);
    chk("done_state_not_ready", 32'(wr_ready), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("swap1_front", 32'(front_sel), 32'd1);
    chk("swap1_ready", 32'(frame_ready), 32'd1);
    rd(0); rd(7); rd(8); rd(19); idle(1);
    chk("read_idx19", 32'(rd_data), 32'h113);
    idle(1);
    read_all();

    // Second frame 0x200.. while the front is read randomly
    write_pixels(32'h200, 0, int'(FP) - 1);
    idle(1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk("swap2_front", 32'(front_sel), 32'd0);
    read_all();

    // Abort after 10 pixels, then a full frame
    write_pixels(32'h3A0, 0, 9);
    write_pixels(32'h300, 0, int'(FP) - 1);
    chk("abort_drop", 32'(drop_cnt), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    read_all();

    // Last pixel coincides with frame start: no swap until the next one
    write_pixels(32'h400, 0, int'(FP) - 2);
    cycle(1'b1, 1'b0, DW'(32'h400 + FP - 1), 1'b1, 1'b0, '0);
    chk("no_swap_same_cycle", 32'(front_sel), 32'd1);
    cycle(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, '0);
    rd(5);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(6));
    idle(1);
    chk("old_front_read", 32'(rd_data), 32'h306);
    idle(1);
    read_all();

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
            DW'($urandom), 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
    idle(3);

    // Reset mid-fill with reads in flight
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    write_pixels(32'h500, 0, 7);
    rd(1);
    resetn = 1'b0;
    cycle(1'b1, 1'b0, 16'h5555, 1'b0, 1'b1, AW'(2));
    resetn = 1'b1;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_front", 32'(front_sel), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rd(3); rd(4); idle(3);
    write_pixels(32'h600, 0, int'(FP) - 1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_buffer_pingpong.md
Name: frame_buffer_pingpong

Overview:
Double-buffered (ping-pong) frame store built from parametrised BRAM banks, for the camera-to-display path. A streaming pixel writer fills the back frame using an internal address counter. The display reader fetches the front frame by pixel index with a registered 2-cycle read. Front and back swap only at a display frame boundary, and only once the back frame is complete, so the display never shows a torn frame.

Parameters:
ADDR_WIDTH, 17, width of pixel index and write counter; must be >= clog2(FRAME_PIXELS)
DATA_WIDTH, 16, pixel word width
FRAME_PIXELS, 76800, pixels per frame (320x240)
BANK_DEPTH, 8192, words per BRAM bank; power of two
NUM_BANKS, derived = ceil(FRAME_PIXELS/BANK_DEPTH), banks per frame; 2*NUM_BANKS banks instantiated

Ports:
clk_i  in  1  system clock
resetn_i  in  1  synchronous active-low reset
wr_valid_i  in  1  pixel valid from capture side
wr_sof_i  in  1  qualifies the first pixel of a frame (meaningful only with wr_valid_i)
wr_data_i  in  DATA_WIDTH  pixel data
wr_ready_o  out  1  high when the writer accepts pixels
wr_frame_done_o  out  1  1-cycle pulse when the last pixel of a frame is written
rd_frame_start_i  in  1  1-cycle display vsync pulse; swap point
rd_en_i  in  1  read request
rd_addr_i  in  ADDR_WIDTH  pixel index within the front frame
rd_data_o  out  DATA_WIDTH  read data
rd_valid_o  out  1  qualifies rd_data_o
front_sel_o  out  1  index of the frame being displayed
frame_ready_o  out  1  high once at least one frame has been swapped to front
drop_cnt_o  out  16  count of aborted (truncated) write frames

Behaviour:
- Reset values: wr_ready_o=1, wr_frame_done_o=0, rd_data_o=0, rd_valid_o=0, front_sel_o=0, frame_ready_o=0, drop_cnt_o=0. Write state is W_IDLE and the write counter is 0. Memory contents are not cleared.
- Reset asserted mid-frame: all state returns to the reset values on the next edge. In-flight reads are discarded and rd_valid_o is 0 on the next cycle.
- Write FSM, W_IDLE:
  - wr_ready_o=1.
  - Pixels without sof are dropped silently.
  - A valid pixel with sof is written to back index 0; counter=1; go to W_FILL.
- Write FSM, W_FILL:
  - wr_ready_o=1. Each valid pixel is written at the counter value, then the counter increments.
  - Valid pixel with sof: counts as an abort. drop_cnt_o increments, saturating at 0xFFFF. The pixel is written at index 0, counter=1, and the FSM stays in W_FILL.
  - Writing index FRAME_PIXELS-1 goes to W_DONE and pulses wr_frame_done_o in the following cycle.
- Write FSM, W_DONE:
  - wr_ready_o=0. All offered pixels, including sof, are ignored; drop_cnt_o is unchanged.
  - rd_frame_start_i in this state toggles front_sel_o, sets frame_ready_o=1 (sticky until reset), and moves to W_IDLE. The writer now targets the old front frame.
- Swap rule: a swap happens only when the state is already W_DONE in the cycle rd_frame_start_i is high.
  - If the last pixel is written in the same cycle as rd_frame_start_i, there is no swap; the swap waits for the next frame start.
  - rd_frame_start_i in W_IDLE or W_FILL has no effect.
- Back frame = ~front_sel_o. Write and read always target different frames, so no same-bank read/write collision is possible.
- Bank mapping: bank = index[ADDR_WIDTH-1:log2(BANK_DEPTH)], local address = the low log2(BANK_DEPTH) bits. Physical bank = frame*NUM_BANKS + bank.
- Read pipeline, 2-cycle latency:
  - Cycle 0: rd_en_i/rd_addr_i sampled. The front frame is captured with the request, so a swap in cycles 1-2 does not affect the in-flight read.
  - Cycle 1: BRAM output available; bank select registered.
  - Cycle 2: muxed data registered to rd_data_o; rd_valid_o=1.
  - Fully pipelined: one request per cycle.
  - rd_valid_o = rd_en_i delayed by 2 cycles. rd_data_o holds its value when rd_valid_o=0.
- Read boundary cases:
  - rd_addr_i >= FRAME_PIXELS: rd_data_o=0 with rd_valid_o=1.
  - While frame_ready_o=0: reads return 0 with rd_valid_o=1.

Test Plan:
- Params FRAME_PIXELS=20, BANK_DEPTH=8 (3 banks/frame). Write 20 pixels 0x100..0x113 with sof on the first, then pulse rd_frame_start_i -> wr_frame_done_o pulses once; front_sel_o=1; frame_ready_o=1; reads of idx 0, 7, 8, 19 return 0x100, 0x107, 0x108, 0x113, each 2 cycles after request, with rd_valid_o high.
- Back-to-back reads of idx 0..19 -> 20 consecutive rd_valid_o cycles with matching data. idx 20 and 31 -> 0.
- During the second frame write, read the front frame -> data unchanged (0x1xx). Write 0x2xx, pulse frame start -> front_sel_o=0 and reads return 0x2xx.
- After 10 pixels, assert sof -> drop_cnt_o=1. The following 20 pixels complete a frame correctly; no stale pixels appear after the swap.
- Frame completes in the same cycle as rd_frame_start_i -> no swap. Pixels offered in W_DONE are ignored (wr_ready_o=0). The next frame-start swaps. Read issued the cycle before the swap returns old-front data.
- Before any swap, reads return 0 and frame_ready_o=0. Reset asserted mid-fill and with a read pending -> all outputs return to reset values next cycle; rd_valid_o=0.
